// File: rtl/mmsa_param_core_if.sv
// Operand-load and result-stream signal bundle for mmsa_param_core.
interface mmsa_param_core_if #(
  parameter int unsigned DIM    = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 2 * DATA_W + $clog2(DIM) + 2
);
  localparam int unsigned MsW = $clog2(DIM);

  logic              in_valid;
  logic [MsW-1:0]    mat_size;
  logic              acc_mode;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_ready;
  logic              busy;
  logic              out_valid;
  logic [OUT_W-1:0]  out_value;
  logic              out_last;

  modport master (
    output in_valid, mat_size, acc_mode, in_a, in_b, out_ready,
    input  busy, out_valid, out_value, out_last
  );

  modport slave (
    input  in_valid, mat_size, acc_mode, in_a, in_b, out_ready,
    output busy, out_valid, out_value, out_last
  );
endinterface

// File: rtl/mmsa_param_core.sv
// Output-stationary DIM x DIM systolic matrix multiplier with accumulate mode and a
// ready/valid result stream. The PE accumulators double as the held C matrix.
module mmsa_param_core #(
  parameter int unsigned DIM    = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 2 * DATA_W + $clog2(DIM) + 2
) (
  input logic              clk,
  input logic              rst_n,
  mmsa_param_core_if.slave bus
);
  localparam int unsigned IdxW  = $clog2(DIM);
  localparam int unsigned CntW  = $clog2(3 * DIM);
  localparam int unsigned ProdW = 2 * DATA_W;

  typedef enum logic [1:0] {StIdle, StLoad, StCompute, StOutput} state_e;

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          n_m1_q, n_m1_d;
  logic [IdxW-1:0]          row_q, row_d, col_q, col_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic signed [DATA_W-1:0] a_mem_q [DIM][DIM];
  logic signed [DATA_W-1:0] a_mem_d [DIM][DIM];
  logic signed [DATA_W-1:0] b_mem_q [DIM][DIM];
  logic signed [DATA_W-1:0] b_mem_d [DIM][DIM];
  logic signed [DATA_W-1:0] a_pipe_q [DIM][DIM-1];
  logic signed [DATA_W-1:0] a_pipe_d [DIM][DIM-1];
  logic signed [DATA_W-1:0] b_pipe_q [DIM-1][DIM];
  logic signed [DATA_W-1:0] b_pipe_d [DIM-1][DIM];
  logic signed [OUT_W-1:0]  acc_q [DIM][DIM];
  logic signed [OUT_W-1:0]  acc_d [DIM][DIM];
  logic                     busy_q, busy_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [OUT_W-1:0]         out_value_q, out_value_d;

  logic signed [DATA_W-1:0] a_edge [DIM];
  logic signed [DATA_W-1:0] b_edge [DIM];
  logic signed [DATA_W-1:0] a_in [DIM][DIM];
  logic signed [DATA_W-1:0] b_in [DIM][DIM];
  logic signed [OUT_W-1:0]  mac [DIM][DIM];

  // Skewed feed: row i of A and column i of B enter i cycles late.
  always_comb begin : edge_feed
    int              k;
    logic [IdxW-1:0] k_idx;
    k     = 0;
    k_idx = '0;
    for (int i = 0; i < DIM; i++) begin
      k         = int'(cnt_q) - i;
      k_idx     = k[IdxW-1:0];
      a_edge[i] = '0;
      b_edge[i] = '0;
      if (i <= int'(n_m1_q) && k >= 0 && k <= int'(n_m1_q)) begin
        a_edge[i] = a_mem_q[i][k_idx];
        b_edge[i] = b_mem_q[k_idx][i];
      end
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      logic signed [ProdW-1:0] prod;
      if (j == 0) begin : g_a_edge
        assign a_in[i][j] = a_edge[i];
      end else begin : g_a_pipe
        assign a_in[i][j] = a_pipe_q[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in[i][j] = b_edge[j];
      end else begin : g_b_pipe
        assign b_in[i][j] = b_pipe_q[i-1][j];
      end
      assign prod      = a_in[i][j] * b_in[i][j];
      assign mac[i][j] = acc_q[i][j] + {{(OUT_W - ProdW){prod[ProdW-1]}}, prod};
    end
  end

  always_comb begin : next_state
    logic [IdxW-1:0] nr, nc;
    state_d     = state_q;
    n_m1_d      = n_m1_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    a_mem_d     = a_mem_q;
    b_mem_d     = b_mem_q;
    a_pipe_d    = a_pipe_q;
    b_pipe_d    = b_pipe_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_last_d  = out_last_q;
    nr          = row_q;
    nc          = col_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          n_m1_d        = bus.mat_size;
          a_mem_d[0][0] = bus.in_a;
          b_mem_d[0][0] = bus.in_b;
          row_d         = '0;
          col_d         = IdxW'(1);
          cnt_d         = '0;
          for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM - 1; j++) a_pipe_d[i][j] = '0;
          end
          for (int i = 0; i < DIM - 1; i++) begin
            for (int j = 0; j < DIM; j++) b_pipe_d[i][j] = '0;
          end
          // Held C survives only inside the new n x n window, and only in accumulate mode.
          for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
              if (!(bus.acc_mode && i <= int'(bus.mat_size) && j <= int'(bus.mat_size))) begin
                acc_d[i][j] = '0;
              end
            end
          end
          state_d = (bus.mat_size == '0) ? StCompute : StLoad;
        end
      end
      StLoad: begin
        if (bus.in_valid) begin
          a_mem_d[row_q][col_q] = bus.in_a;
          b_mem_d[row_q][col_q] = bus.in_b;
          if (col_q == n_m1_q) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == n_m1_q) begin
              state_d = StCompute;
              cnt_d   = '0;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StCompute: begin
        for (int i = 0; i < DIM; i++) begin
          for (int j = 0; j < DIM - 1; j++) a_pipe_d[i][j] = a_in[i][j];
        end
        for (int i = 0; i < DIM - 1; i++) begin
          for (int j = 0; j < DIM; j++) b_pipe_d[i][j] = b_in[i][j];
        end
        acc_d = mac;
        cnt_d = cnt_q + 1'b1;
        // 3n-2 feed cycles then one drain cycle; the drain only adds zero products.
        if (int'(cnt_q) == 3 * int'(n_m1_q) + 1) begin
          state_d     = StOutput;
          out_valid_d = 1'b1;
          out_value_d = acc_q[0][0];
          out_last_d  = (n_m1_q == '0);
          row_d       = '0;
          col_d       = '0;
        end
      end
      StOutput: begin
        if (bus.out_ready) begin
          if (out_last_q) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_value_d = '0;
            out_last_d  = 1'b0;
          end else begin
            if (col_q == n_m1_q) begin
              nr = row_q + 1'b1;
              nc = '0;
            end else begin
              nc = col_q + 1'b1;
            end
            row_d       = nr;
            col_d       = nc;
            out_value_d = acc_q[nr][nc];
            out_last_d  = (nr == n_m1_q) && (nc == n_m1_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= StIdle;
      n_m1_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          a_mem_q[i][j] <= '0;
          b_mem_q[i][j] <= '0;
          acc_q[i][j]   <= '0;
        end
        for (int j = 0; j < DIM - 1; j++) a_pipe_q[i][j] <= '0;
      end
      for (int i = 0; i < DIM - 1; i++) begin
        for (int j = 0; j < DIM; j++) b_pipe_q[i][j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      n_m1_q      <= n_m1_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_last_q  <= out_last_d;
      a_mem_q     <= a_mem_d;
      b_mem_q     <= b_mem_d;
      a_pipe_q    <= a_pipe_d;
      b_pipe_q    <= b_pipe_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_mmsa_param_core.sv
// Bench for mmsa_param_core: directed job table, abort sequence and random jobs
// checked against a plain matrix-arithmetic model.
module tb_mmsa_param_core;
  localparam int unsigned DIM    = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OUT_W  = 2 * DATA_W + $clog2(DIM) + 2;
  localparam int unsigned MS_W   = $clog2(DIM);
  localparam int unsigned NE     = DIM * DIM;

  typedef struct packed {
    int                           n;
    logic                         acc;
    logic                         gaps;
    int                           rmode;  // 0: always ready, 1: fixed pattern, 2: random
    logic [NE-1:0][DATA_W-1:0]    a;      // row-major, index i*n+j
    logic [NE-1:0][DATA_W-1:0]    b;
    logic [NE-1:0][OUT_W-1:0]     exp_c;
  } job_t;

  logic clk;
  logic rst_n;
  int   n_checks, n_fails, cyc, last_beat_cyc, busy_lows;
  logic signed [OUT_W-1:0] cprev [DIM][DIM];
  job_t tab [5];
  job_t jb;

  mmsa_param_core_if #(.DIM(DIM), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  mmsa_param_core #(.DIM(DIM), .DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) cprev[i][j] = '0;
  endtask

  // C = (acc ? C_prev : 0) + A*B inside the n x n window, zero outside; wraps at OUT_W.
  task automatic model_job(input job_t j, output logic [NE-1:0][OUT_W-1:0] res);
    logic signed [OUT_W-1:0] nc [DIM][DIM];
    longint s;
    res = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        nc[r][c] = '0;
        if (r < j.n && c < j.n) begin
          s = j.acc ? longint'(cprev[r][c]) : 64'sd0;
          for (int k = 0; k < j.n; k++)
            s += longint'($signed(j.a[r*j.n+k])) * longint'($signed(j.b[k*j.n+c]));
          nc[r][c]        = OUT_W'(s);
          res[r*j.n+c]    = OUT_W'(s);
        end
      end
    end
    cprev = nc;
  endtask

  function automatic job_t mk2(input logic acc, input int rmode,
                               input int a0, input int a1, input int a2, input int a3,
                               input int b0, input int b1, input int b2, input int b3,
                               input int e0, input int e1, input int e2, input int e3);
    job_t j;
    j          = '0;
    j.n        = 2;
    j.acc      = acc;
    j.rmode    = rmode;
    j.a[0]     = DATA_W'(a0); j.a[1] = DATA_W'(a1); j.a[2] = DATA_W'(a2); j.a[3] = DATA_W'(a3);
    j.b[0]     = DATA_W'(b0); j.b[1] = DATA_W'(b1); j.b[2] = DATA_W'(b2); j.b[3] = DATA_W'(b3);
    j.exp_c[0] = OUT_W'(e0);  j.exp_c[1] = OUT_W'(e1);
    j.exp_c[2] = OUT_W'(e2);  j.exp_c[3] = OUT_W'(e3);
    return j;
  endfunction

  task automatic drive_beats(input job_t j);
    for (int k = 0; k < j.n * j.n; k++) begin
      if (j.gaps && k > 0) begin
        bus.in_valid = 1'b0;
        bus.in_a     = DATA_W'($urandom);
        bus.in_b     = DATA_W'($urandom);
        tick();
        if (!bus.busy) busy_lows++;
      end
      bus.in_valid  = 1'b1;
      bus.in_a      = j.a[k];
      bus.in_b      = j.b[k];
      bus.mat_size  = (k == 0) ? MS_W'(j.n - 1) : MS_W'($urandom);
      bus.acc_mode  = (k == 0) ? j.acc : 1'($urandom);
      last_beat_cyc = cyc;
      tick();
      if (!bus.busy) busy_lows++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input job_t j, input logic [NE-1:0][OUT_W-1:0] expv);
    int               nn, got, waited, guard;
    logic             rdy, stall_prev, pl;
    logic [OUT_W-1:0] pv;
    logic [6:0]       pat;
    pat = 7'b1011001;  // ready sequence 1,0,0,1,1,0,1 read from bit 0 upward
    nn = j.n * j.n; got = 0; waited = 0; guard = 0;
    stall_prev = 1'b0; pv = '0; pl = 1'b0; rdy = 1'b0;

    // Garbage beats during COMPUTE must be ignored.
    while (!bus.out_valid && waited < 100) begin
      bus.in_valid = 1'($urandom);
      bus.in_a     = DATA_W'($urandom);
      bus.in_b     = DATA_W'($urandom);
      bus.mat_size = MS_W'($urandom);
      bus.acc_mode = 1'($urandom);
      tick();
      waited++;
      if (!bus.busy) busy_lows++;
    end
    bus.in_valid = 1'b0;
    check("first_valid_latency", longint'(cyc - last_beat_cyc), longint'(3 * j.n));

    while (got < nn && guard < 200) begin
      case (j.rmode)
        0:       rdy = 1'b1;
        1:       rdy = pat[guard % 7];
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      bus.out_ready = rdy;
      if (stall_prev) begin
        check("stall_hold_valid", longint'(bus.out_valid), 1);
        check("stall_hold_value", longint'($signed(bus.out_value)), longint'($signed(pv)));
        check("stall_hold_last", longint'(bus.out_last), longint'(pl));
      end
      if (!bus.busy) busy_lows++;
      stall_prev = bus.out_valid && !rdy;
      pv         = bus.out_value;
      pl         = bus.out_last;
      if (bus.out_valid && rdy) begin
        check($sformatf("value[%0d]", got), longint'($signed(bus.out_value)),
              longint'($signed(expv[got])));
        check($sformatf("last[%0d]", got), longint'(bus.out_last), longint'(got == nn - 1));
        got++;
      end
      tick();
      guard++;
    end
    check("transfer_count", longint'(got), longint'(nn));
    check("valid_drop_after_last", longint'(bus.out_valid), 0);
    check("idle_after_last", longint'(bus.busy), 0);
    check("busy_held_during_job", longint'(busy_lows), 0);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_job(input job_t j, input bit use_table);
    logic [NE-1:0][OUT_W-1:0] mres;
    model_job(j, mres);
    busy_lows = 0;
    drive_beats(j);
    collect(j, use_table ? j.exp_c : mres);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, longint'(bus.busy), 0);
    check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
    check({tag, "_out_value"}, longint'(bus.out_value), 0);
    check({tag, "_out_last"}, longint'(bus.out_last), 0);
  endtask

  initial begin
    n_checks = 0; n_fails = 0; cyc = 0; last_beat_cyc = 0; busy_lows = 0;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mat_size  = '0;
    bus.acc_mode  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    model_clear();

    tab[0] = mk2(1'b0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50);
    tab[1] = mk2(1'b1, 0, 1, 2, 3, 4, 5, 6, 7, 8, 38, 44, 86, 100);
    tab[2]          = '0;
    tab[2].n        = 1;
    tab[2].a[0]     = DATA_W'(-3);
    tab[2].b[0]     = DATA_W'(5);
    tab[2].exp_c[0] = OUT_W'(-15);
    tab[3]          = '0;
    tab[3].n        = 4;
    tab[3].gaps     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        tab[3].a[i*4+j]     = (i == j) ? DATA_W'(1) : '0;
        tab[3].b[i*4+j]     = DATA_W'(16 * i + j);
        tab[3].exp_c[i*4+j] = OUT_W'(16 * i + j);
      end
    end
    tab[4] = mk2(1'b0, 1, 1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50);

    tick();
    tick();
    check_outputs_zero("reset");
    rst_n = 1'b0;
    tick();
    check_outputs_zero("post_reset");

    for (int t = 0; t < 5; t++) run_job(tab[t], 1'b1);

    // Abort mid-COMPUTE; held C must be wiped so the following accumulate job starts from 0.
    drive_beats(tab[0]);
    tick();
    tick();
    check("busy_before_abort", longint'(bus.busy), 1);
    rst_n = 1'b1;
    #1;
    check_outputs_zero("abort_async");
    tick();
    check_outputs_zero("abort_held");
    rst_n = 1'b0;
    model_clear();
    tick();
    check_outputs_zero("abort_release");
    run_job(mk2(1'b1, 0, 1, 0, 0, 1, 2, 3, 4, 5, 2, 3, 4, 5), 1'b1);

    for (int r = 0; r < 20; r++) begin
      jb       = '0;
      jb.n     = int'($urandom_range(1, DIM));
      jb.acc   = 1'($urandom);
      jb.gaps  = 1'($urandom);
      jb.rmode = 2;
      for (int k = 0; k < NE; k++) begin
        jb.a[k] = DATA_W'($urandom);
        jb.b[k] = DATA_W'($urandom);
      end
      run_job(jb, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/mmsa_param_core.md
Name: mmsa_param_core

Overview:
- Parametrised successor to the MMSA matrix-multiply engine: computes C = A x B for square matrices of size n = 1..DIM on an output-stationary DIM x DIM systolic PE array.
- Differences from the MMSA engine: word-parallel operand load, a ready/valid result stream with backpressure, and an accumulate mode (C_new = C_prev + A x B).
- Sits between the input-staging logic and the result serializer in the MMSA datapath.

Parameters:
- DIM, 4, maximum matrix dimension (2..8).
- DATA_W, 8, signed operand width, two's complement.
- OUT_W, 2*DATA_W+$clog2(DIM)+2, signed result and accumulator width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-high: asserted at 1 despite the name.
- in_valid  input  1  operand beat valid.
- mat_size  input  $clog2(DIM)  n-1; sampled on first beat only.
- acc_mode  input  1  1 = add result to held C; sampled on first beat only.
- in_a  input  DATA_W  A element, row-major.
- in_b  input  DATA_W  B element, row-major.
- out_ready  input  1  downstream accepts result.
- busy  output  1  high in every state except IDLE.
- out_valid  output  1  result element valid.
- out_value  output  OUT_W  C element, row-major.
- out_last  output  1  high with the final element C[n-1][n-1].

Behaviour:
- Reset (async, rst_n=1): FSM to IDLE; all of the following cleared to 0: busy, out_valid, out_value, out_last, operand stores, PE accumulators, held C matrix, counters.
- States: IDLE -> LOAD -> COMPUTE -> OUTPUT -> IDLE.
- IDLE: first in_valid beat latches n, acc_mode and element (0,0); moves to LOAD, or directly to COMPUTE when n=1.
- LOAD:
  - Each in_valid beat stores one A and one B element; the beat counter advances only on in_valid=1.
  - Gaps are allowed and pause loading.
  - After beat n*n, moves to COMPUTE.
- COMPUTE:
  - Lasts exactly 3n-1 cycles: 3n-2 skewed feed cycles (row i of A delayed i cycles, column j of B delayed j cycles) plus 1 drain cycle.
  - PE(i,j) initial value is C_prev(i,j) if acc_mode=1, otherwise 0.
  - PEs outside n x n are held at 0.
- Timing: if the last load beat is sampled at edge k, COMPUTE spans cycles k+1..k+3n-1 and out_valid is first high in cycle k+3n.
- OUTPUT:
  - Streams n*n elements row-major. An element transfers when out_valid and out_ready are both 1.
  - While out_ready=0, out_value and out_last hold stable.
  - After the transfer with out_last=1: out_valid drops next cycle, FSM returns to IDLE, results are retained as C_prev.
- Arithmetic:
  - Products are DATA_W x DATA_W signed, sign-extended to OUT_W.
  - Sums wrap modulo 2^OUT_W; no saturation.
  - Only repeated accumulation can overflow.
- in_valid outside IDLE/LOAD is ignored. mat_size and acc_mode are ignored after the first beat.
- acc_mode=1 after reset or after an acc_mode=0 job: C_prev is whatever is held (0 after reset).
- A new job may start in the cycle after out_valid falls.
- Reset mid-operation: immediate abort, everything cleared including C_prev; no partial output.

Test Plan:
- n=2 (mat_size=1), A=[1,2;3,4], B=[5,6;7,8], acc_mode=0, out_ready=1 -> stream 19,22,43,50; out_last only on 50; first out_valid exactly 3n=6 cycles after the last beat.
- Repeat the same job with acc_mode=1 -> 38,44,86,100.
- n=1, A=-3, B=5 (DATA_W=8) -> single output -15 with out_last=1; load beats sampled 1.
- n=4, A=identity, B[i][j]=16*i+j, with in_valid gaps every other beat -> output equals B row-major; busy stays high throughout.
- Backpressure: n=2 job, out_ready toggled 1,0,0,1,1,0,1 -> exactly 4 transfers, each value stable while stalled, no element lost or duplicated.
- Assert rst_n during COMPUTE, then run an n=2 job with acc_mode=1 and A=[1,0;0,1], B=[2,3;4,5] -> 2,3,4,5 (C_prev cleared); all outputs 0 while reset is asserted.
